// File: rtl/uop_dispatch_queue.sv
// Micro-op dispatch queue: decoded instructions in (1-2 uops), one uop out per cycle.
// Optional combinational empty-queue bypass: define UOP_DISPATCH_BYPASS_EN.

package uop_pkg;
   typedef enum logic [4:0] {
      UOP_INT_ALU  = 5'd0,
      UOP_INT_MUL  = 5'd1,
      UOP_LD_U8    = 5'd2,
      UOP_LD_U32   = 5'd3,
      UOP_ST       = 5'd4,
      UOP_BRANCH   = 5'd5,
      UOP_CAP_JUMP = 5'd6,
      UOP_LINK     = 5'd7
   } uop_tag_t;
endpackage

module uop_dispatch_queue
   import uop_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int PC_W  = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       dec_valid,
   output logic                       dec_ready,
   input  logic [1:0]                 dec_count,
   input  uop_tag_t                   dec_tag0,
   input  uop_tag_t                   dec_tag1,
   input  logic [PC_W-1:0]            dec_pc,
   output logic                       uop_valid,
   input  logic                       uop_ready,
   output uop_tag_t                   uop_tag,
   output logic [PC_W-1:0]            uop_pc,
   output logic                       uop_last,
   output logic                       uop_illegal,
   output logic [$clog2(DEPTH):0]     occ
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   uop_tag_t        tag_mem  [DEPTH];
   logic [PC_W-1:0] pc_mem   [DEPTH];
   logic            last_mem [DEPTH];
   logic            ill_mem  [DEPTH];

   logic            two_uops, accept, pop, bypass_take, empty;
   logic            w0_en, w1_en, w0_last, w0_ill;
   uop_tag_t        w0_tag;
   logic [AW-1:0]   wa0, wa1;
   logic [1:0]      n_wr;

   always_comb begin
      occ       = wr_ptr_q - rd_ptr_q;
      empty     = (occ == '0);
      two_uops  = dec_count[1];
      dec_ready = !rst && !flush && (occ <= PW'(DEPTH - 2));
      accept    = dec_valid && dec_ready;
`ifdef UOP_DISPATCH_BYPASS_EN
      bypass_take = accept && empty && uop_ready;
`else
      bypass_take = 1'b0;
`endif
      // When the first uop is consumed by bypass, only the second one is stored.
      w0_en   = accept && !(bypass_take && !two_uops);
      w1_en   = accept && two_uops && !bypass_take;
      w0_tag  = bypass_take ? dec_tag1 : dec_tag0;
      w0_last = bypass_take ? 1'b1 : !two_uops;
      w0_ill  = bypass_take ? 1'b0 : (dec_count == 2'd0);
      wa0     = wr_ptr_q[AW-1:0];
      wa1     = wr_ptr_q[AW-1:0] + AW'(1);
      n_wr    = {1'b0, w0_en} + {1'b0, w1_en};

      pop     = !rst && !flush && !empty && uop_ready;

      rd_ptr_d = flush ? '0 : rd_ptr_q + PW'(pop);
      wr_ptr_d = flush ? '0 : wr_ptr_q + PW'(n_wr);

      uop_valid   = !rst && !flush && !empty;
      uop_tag     = UOP_INT_ALU;
      uop_pc      = '0;
      uop_last    = 1'b0;
      uop_illegal = 1'b0;
      if (!empty) begin
         uop_tag     = tag_mem[rd_ptr_q[AW-1:0]];
         uop_pc      = pc_mem[rd_ptr_q[AW-1:0]];
         uop_last    = last_mem[rd_ptr_q[AW-1:0]];
         uop_illegal = ill_mem[rd_ptr_q[AW-1:0]];
      end
`ifdef UOP_DISPATCH_BYPASS_EN
      else if (!rst && !flush) begin
         uop_valid = dec_valid;
         if (dec_valid) begin
            uop_tag     = dec_tag0;
            uop_pc      = dec_pc;
            uop_last    = !two_uops;
            uop_illegal = (dec_count == 2'd0);
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
      end
   end

   // Storage is never reset; head fields are masked while the queue is empty.
   always_ff @(posedge clk) begin
      if (w0_en) begin
         tag_mem[wa0]  <= w0_tag;
         pc_mem[wa0]   <= dec_pc;
         last_mem[wa0] <= w0_last;
         ill_mem[wa0]  <= w0_ill;
      end
      if (w1_en) begin
         tag_mem[wa1]  <= dec_tag1;
         pc_mem[wa1]   <= dec_pc;
         last_mem[wa1] <= 1'b1;
         ill_mem[wa1]  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uop_dispatch_queue.sv
// Directed bench for uop_dispatch_queue (DEPTH=8, default build without bypass).
module tb_uop_dispatch_queue;
   import uop_pkg::*;

   logic            clk = 1'b0;
   logic            rst, flush, dec_valid, dec_ready, uop_valid, uop_ready;
   logic            uop_last, uop_illegal;
   logic [1:0]      dec_count;
   uop_tag_t        dec_tag0, dec_tag1, uop_tag;
   logic [31:0]     dec_pc, uop_pc;
   logic [3:0]      occ;

   int total = 0;
   int bad   = 0;

   uop_dispatch_queue #(.DEPTH(8), .PC_W(32)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_count(dec_count),
      .dec_tag0(dec_tag0), .dec_tag1(dec_tag1), .dec_pc(dec_pc),
      .uop_valid(uop_valid), .uop_ready(uop_ready), .uop_tag(uop_tag),
      .uop_pc(uop_pc), .uop_last(uop_last), .uop_illegal(uop_illegal),
      .occ(occ)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change 1 time unit after the edge, checks happen mid-cycle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   initial begin
      int accepts;
      int sent;
      int recv;
      int cyc;
      logic take_in;
      logic take_out;

      rst = 1'b1; flush = 1'b0; dec_valid = 1'b0; uop_ready = 1'b0;
      dec_count = 2'd1; dec_tag0 = UOP_INT_ALU; dec_tag1 = UOP_INT_ALU; dec_pc = '0;
      tick(); tick();
      settle();
      chk("rst_dec_ready", dec_ready, 0);
      chk("rst_uop_valid", uop_valid, 0);
      tick();
      rst = 1'b0;
      settle();
      chk("post_rst_occ", occ, 0);
      chk("post_rst_valid", uop_valid, 0);
      chk("post_rst_ready", dec_ready, 1);
      chk("post_rst_tag", uop_tag, 0);
      chk("post_rst_pc", uop_pc, 0);
      chk("post_rst_last", uop_last, 0);
      chk("post_rst_ill", uop_illegal, 0);

      // Single uop
      tick();
      dec_valid = 1'b1; dec_count = 2'd1; dec_tag0 = UOP_LD_U8; dec_pc = 32'h100; uop_ready = 1'b1;
      tick();
      dec_valid = 1'b0;
      settle();
      chk("single_valid", uop_valid, 1);
      chk("single_tag", uop_tag, UOP_LD_U8);
      chk("single_pc", uop_pc, 32'h100);
      chk("single_last", uop_last, 1);
      chk("single_ill", uop_illegal, 0);
      chk("single_occ1", occ, 1);
      tick();
      settle();
      chk("single_occ0", occ, 0);
      chk("single_empty", uop_valid, 0);

      // Two-uop split
      uop_ready = 1'b0;
      dec_valid = 1'b1; dec_count = 2'd2; dec_tag0 = UOP_CAP_JUMP; dec_tag1 = UOP_LINK; dec_pc = 32'h200;
      tick();
      dec_valid = 1'b0; uop_ready = 1'b1;
      settle();
      chk("split_occ2", occ, 2);
      chk("split_tag0", uop_tag, UOP_CAP_JUMP);
      chk("split_pc0", uop_pc, 32'h200);
      chk("split_last0", uop_last, 0);
      tick();
      settle();
      chk("split_tag1", uop_tag, UOP_LINK);
      chk("split_pc1", uop_pc, 32'h200);
      chk("split_last1", uop_last, 1);
      chk("split_occ1", occ, 1);
      tick();
      settle();
      chk("split_occ0", occ, 0);

      // Fill and backpressure
      uop_ready = 1'b0;
      dec_valid = 1'b1; dec_count = 2'd2; dec_tag0 = UOP_LD_U32; dec_tag1 = UOP_ST; dec_pc = 32'h300;
      accepts = 0;
      for (int i = 0; i < 6; i++) begin
         settle();
         if (dec_ready) accepts++;
         tick();
      end
      dec_valid = 1'b0;
      settle();
      chk("fill_accepts", 32'(accepts), 4);
      chk("fill_occ", occ, 8);
      chk("fill_ready", dec_ready, 0);
      chk("fill_valid", uop_valid, 1);
      chk("fill_head_tag", uop_tag, UOP_LD_U32);
      uop_ready = 1'b1;
      tick();
      uop_ready = 1'b0;
      settle();
      chk("pop1_occ", occ, 7);
      chk("pop1_ready", dec_ready, 0);
      chk("pop1_head_tag", uop_tag, UOP_ST);
      uop_ready = 1'b1;
      tick();
      uop_ready = 1'b0;
      settle();
      chk("pop2_occ", occ, 6);
      chk("pop2_ready", dec_ready, 1);
      uop_ready = 1'b1;
      tick();
      uop_ready = 1'b0;
      settle();
      chk("pre_flush_occ", occ, 5);

      // Flush with a competing enqueue
      flush = 1'b1; dec_valid = 1'b1; dec_count = 2'd1; dec_tag0 = UOP_BRANCH; dec_pc = 32'h444;
      uop_ready = 1'b1;
      settle();
      chk("flush_dec_ready", dec_ready, 0);
      chk("flush_uop_valid", uop_valid, 0);
      tick();
      flush = 1'b0; dec_valid = 1'b0;
      settle();
      chk("flush_occ", occ, 0);
      chk("flush_valid", uop_valid, 0);
      dec_valid = 1'b1; dec_count = 2'd1; dec_tag0 = UOP_INT_MUL; dec_pc = 32'h400;
      tick();
      dec_valid = 1'b0;
      settle();
      chk("postflush_tag", uop_tag, UOP_INT_MUL);
      chk("postflush_pc", uop_pc, 32'h400);
      chk("postflush_occ", occ, 1);
      tick();

      // Decode miss
      dec_valid = 1'b1; dec_count = 2'd0; dec_tag0 = UOP_INT_ALU; dec_tag1 = UOP_LINK; dec_pc = 32'h3C;
      tick();
      dec_valid = 1'b0;
      settle();
      chk("miss_valid", uop_valid, 1);
      chk("miss_tag", uop_tag, UOP_INT_ALU);
      chk("miss_pc", uop_pc, 32'h3C);
      chk("miss_ill", uop_illegal, 1);
      chk("miss_last", uop_last, 1);
      chk("miss_occ", occ, 1);
      tick();
      settle();
      chk("miss_drained", occ, 0);

      // Wrap-around stream with random backpressure
      sent = 0; recv = 0; cyc = 0;
      dec_count = 2'd1; dec_tag0 = UOP_LD_U8;
      while ((recv < 20) && (cyc < 400)) begin
         dec_valid = (sent < 20);
         dec_pc    = 32'h1000 + 32'(sent);
         uop_ready = 1'($urandom_range(0, 1));
         settle();
         take_in  = dec_valid && dec_ready;
         take_out = uop_valid && uop_ready;
         if (take_out) begin
            chk("wrap_pc", uop_pc, 64'(32'h1000 + 32'(recv)));
            recv++;
         end
         if (take_in) sent++;
         tick();
         cyc++;
      end
      dec_valid = 1'b0; uop_ready = 1'b0;
      settle();
      chk("wrap_count", 32'(recv), 20);
      chk("wrap_occ", occ, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/uop_dispatch_queue.md
# uop_dispatch_queue

Micro-op dispatch queue directly downstream of instruction decode. Accepts one decoded instruction per cycle as up to two `uop_pkg::uop_tag_t` micro-ops, buffers them in a ring buffer, and presents them to the backend one per cycle under a valid/ready handshake. Decode misses are tagged as illegal. A pipeline flush empties the queue.

## Interface

**Parameters**
- `DEPTH`, default 8. Entries; power of two, ≥4.
- `PC_W`, default 32. Width of the instruction address carried with each uop.

**Ports**
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  discard all queued and incoming uops.
- `dec_valid`  in  1  decoded instruction present.
- `dec_ready`  out  1  queue accepts an instruction this cycle.
- `dec_count`  in  2  uops in the instruction (0 means decode miss).
- `dec_tag0`  in  uop_tag_t  first uop.
- `dec_tag1`  in  uop_tag_t  second uop.
- `dec_pc`  in  PC_W  instruction address.
- `uop_valid`  out  1  head uop present.
- `uop_ready`  in  1  backend accepts the head uop.
- `uop_tag`  out  uop_tag_t  head tag.
- `uop_pc`  out  PC_W  head instruction address.
- `uop_last`  out  1  head is the final uop of its instruction.
- `uop_illegal`  out  1  head came from a decode miss.
- `occ`  out  $clog2(DEPTH)+1  current entry count.

## Operation

**Storage**
- Ring buffer of {tag, pc, last, illegal}.
- `rd_ptr` and `wr_ptr` carry an extra wrap bit. `occ = wr_ptr - rd_ptr`.

**Enqueue**
- `dec_ready = !rst && !flush && (DEPTH - occ >= 2)`.
- `dec_ready` depends only on registered occupancy. It does not depend on a same-cycle dequeue or on `dec_count`.
- An instruction is accepted when `dec_valid && dec_ready`. The written entries depend on `dec_count`:
  - 1: one entry {tag0, last=1, illegal=0}.
  - 2: {tag0, last=0} at `wr_ptr`, then {tag1, last=1} at `wr_ptr+1`. Both carry `dec_pc`.
  - 0: one entry {tag0 (decode default `UOP_INT_ALU`), last=1, illegal=1}.
  - 3: reserved; handled identically to 2.

**Dequeue**
- `uop_valid = !flush && occ != 0`. The head fields are driven from `rd_ptr`.
- A uop transfers when `uop_valid && uop_ready`, and `rd_ptr` advances by 1.
- Enqueue and dequeue in the same cycle are both applied; `occ` changes by (written − 1).
- Uops leave in strict enqueue order. Pointers wrap modulo DEPTH.

**Flush**
- Flush has priority over everything else.
- In the flush cycle, `dec_ready = 0` and `uop_valid = 0`. No transfer occurs on either side.
- At the next edge, `rd_ptr = wr_ptr = 0`.

**Reset**
- At the next edge, pointers = 0.
- While `rst` is high, `dec_ready = 0` and `uop_valid = 0`.
- After reset: `occ = 0`, and `uop_tag`, `uop_pc`, `uop_last`, `uop_illegal` are all 0.

## Timing

- Enqueue-to-`uop_valid` latency is 1 cycle, or 0 with bypass (see Configuration).
- Throughput is 1 uop out per cycle and 1 instruction in per cycle while ≥2 entries are free.
- A 2-uop instruction occupies the output for ≥2 cycles.
- `dec_ready` is low when `occ > DEPTH-2`, even if a dequeue happens in the same cycle.
- A full queue (`occ == DEPTH`) has `dec_ready = 0` and `uop_valid = 1`.
- An empty queue (`occ == 0`) has `uop_valid = 0` (bypass excepted).

## Configuration

**`UOP_DISPATCH_BYPASS_EN` defined:**
- When `occ == 0` and `!flush`, the output is driven combinationally from the input:
  - `uop_valid = dec_valid`.
  - Head fields come from the incoming first uop.
- If `uop_ready` is high in that cycle, the first uop is consumed directly. Only the remaining uop (count 2) is written to the queue.
- If `uop_ready` is low, all uops are written normally.

**Undefined:** no bypass; every uop passes through storage, giving 1-cycle minimum latency.

## Test plan

- **Single uop:** after reset, enqueue count=1 {`UOP_LD_U8`, pc 0x100} with `uop_ready=1` → next cycle `uop_valid=1`, tag `UOP_LD_U8`, pc 0x100, last=1, illegal=0. Following cycle `occ=0`. With bypass: same outputs in the enqueue cycle.
- **Two-uop split:** enqueue count=2 {`UOP_CAP_JUMP`, `UOP_LINK`}, pc 0x200 → two consecutive uops, both pc 0x200, last 0 then 1.
- **Fill/backpressure:** DEPTH=8, `uop_ready=0`, offer count=2 every cycle → 4 accepts, `occ=8`, `dec_ready=0`. Pop one → `occ=7`, `dec_ready` stays 0. Pop another → `occ=6`, `dec_ready=1`.
- **Decode miss:** count=0, pc 0x3C → one uop, tag `UOP_INT_ALU`, illegal=1, last=1.
- **Flush:** `occ=5` with `dec_valid=1` and `flush=1` → no accept in that cycle. Next cycle `occ=0` and `uop_valid=0`. The first post-flush enqueue emerges correctly.
- **Wrap-around:** 20 count-1 uops with incrementing pc, `uop_ready` toggling pseudo-randomly → all 20 emerge in order, with no loss or duplication.
